// File: rtl/remote_bus_arbiter_if.sv
// Bundle of the per-core remote request lanes and the shared memory port.
// No logic of its own; latency and timing are set by the arbiter.
// Cores hold requests stable while their ready bit is low.
interface remote_bus_arbiter_if #(
    parameter int NUM_CORES     = 4,
    parameter int CORE_ID_WIDTH = $clog2(NUM_CORES)
);
    // core side: flattened per-core slices, slice i = [16*i+15:16*i]
    logic [NUM_CORES*16-1:0]  core_addr;
    logic [NUM_CORES-1:0]     core_wren;
    logic [NUM_CORES-1:0]     core_rden;
    logic [NUM_CORES*16-1:0]  core_write_val;
    logic [NUM_CORES-1:0]     core_ready;
    logic [NUM_CORES*16-1:0]  core_read_val;

    // shared synchronous memory/device port, 1-cycle read latency
    logic [15:0]              mem_addr;
    logic                     mem_wren;
    logic                     mem_rden;
    logic [15:0]              mem_write_val;
    logic [15:0]              mem_read_val;

    // debug: index of the core currently owning the port
    logic [CORE_ID_WIDTH-1:0] grant_id;

    // requester / memory-model side
    modport master (
        output core_addr, core_wren, core_rden, core_write_val, mem_read_val,
        input  core_ready, core_read_val, mem_addr, mem_wren, mem_rden,
        input  mem_write_val, grant_id
    );

    // arbiter side
    modport slave (
        input  core_addr, core_wren, core_rden, core_write_val, mem_read_val,
        output core_ready, core_read_val, mem_addr, mem_wren, mem_rden,
        output mem_write_val, grant_id
    );
endinterface

// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter giving N cores one-at-a-time access to a shared memory port.
// Latency: strobe at +1, ready at +2, read data at +3 from request seen in IDLE; 1 txn / 3 cycles.
// Backpressure: losing cores see ready low and must hold address/data until their ready pulse.
module remote_bus_arbiter #(
    parameter int NUM_CORES     = 4,
    parameter int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
    input logic                  clk,
    input logic                  reset,
    remote_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [CORE_ID_WIDTH-1:0]       grant_q, grant_d;
    logic [CORE_ID_WIDTH-1:0]       last_q, last_d;
    logic                           is_rd_q, is_rd_d;
    logic [NUM_CORES-1:0][15:0]     read_val_q, read_val_d;

    logic [NUM_CORES-1:0][15:0]     addr_arr;
    logic [NUM_CORES-1:0][15:0]     wdat_arr;
    logic [NUM_CORES-1:0]           req;
    logic [CORE_ID_WIDTH-1:0]       cand;
    logic [CORE_ID_WIDTH-1:0]       pick;
    logic                           pick_vld;

    assign addr_arr = bus.core_addr;
    assign wdat_arr = bus.core_write_val;
    assign req      = bus.core_wren | bus.core_rden;

    assign bus.core_read_val = read_val_q;
    assign bus.grant_id      = grant_q;

    // Round-robin search starting just after the last served core; the
    // loop runs from the farthest candidate down so the nearest one wins.
    always_comb begin
        cand     = '0;
        pick     = last_q;
        pick_vld = 1'b0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            cand = CORE_ID_WIDTH'((int'(last_q) + k) % NUM_CORES);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // State register; reset drops straight back to IDLE so strobes stop at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE waits for any request, then a fixed ISSUE/RESP pair.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_vld) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state/grant only, so ready has no
    // combinational path from the core inputs. Address/data always follow
    // the granted core so they are never left floating outside ISSUE.
    always_comb begin
        bus.core_ready    = '0;
        bus.mem_wren      = 1'b0;
        bus.mem_rden      = 1'b0;
        bus.mem_addr      = addr_arr[grant_q];
        bus.mem_write_val = wdat_arr[grant_q];
        case (state_q)
            ST_ISSUE: begin
                bus.mem_wren = bus.core_wren[grant_q];
                bus.mem_rden = bus.core_rden[grant_q] & ~bus.core_wren[grant_q];
            end
            ST_RESP: begin
                bus.core_ready[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state: latch the winner, remember whether it was a read,
    // and capture read data as it arrives during RESP.
    always_comb begin
        grant_d    = grant_q;
        last_d     = last_q;
        is_rd_d    = is_rd_q;
        read_val_d = read_val_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) grant_d = pick;
            end
            ST_ISSUE: begin
                is_rd_d = bus.core_rden[grant_q] & ~bus.core_wren[grant_q];
            end
            ST_RESP: begin
                last_d = grant_q;
                if (is_rd_q) read_val_d[grant_q] = bus.mem_read_val;
            end
            default: ;
        endcase
    end

    // Datapath registers; pointer resets to the top core so core 0 goes first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q    <= '0;
            last_q     <= CORE_ID_WIDTH'(NUM_CORES - 1);
            is_rd_q    <= 1'b0;
            read_val_q <= '0;
        end else begin
            grant_q    <= grant_d;
            last_q     <= last_d;
            is_rd_q    <= is_rd_d;
            read_val_q <= read_val_d;
        end
    end

endmodule

// File: tb/tb_remote_bus_arbiter.sv
module tb_remote_bus_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    remote_bus_arbiter_if #(.NUM_CORES(N)) bus();

    remote_bus_arbiter #(.NUM_CORES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // memory contents: a fixed scramble of the address, plus one marker word
    function automatic logic [15:0] lookup(input logic [15:0] a);
        if (a == 16'h4010) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // synchronous memory model with 1-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_rden === 1'b1) bus.mem_read_val <= lookup(bus.mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic rd,
                           input logic [15:0] a, input logic [15:0] d);
        bus.core_addr[16*i +: 16]      = a;
        bus.core_write_val[16*i +: 16] = d;
        bus.core_wren[i]               = wr;
        bus.core_rden[i]               = rd;
    endtask

    task automatic clear_all();
        bus.core_addr      = '0;
        bus.core_write_val = '0;
        bus.core_wren      = '0;
        bus.core_rden      = '0;
    endtask

    function automatic logic [15:0] caddr(input int i);
        logic [15:0] off;
        off = 16'(i) << 8;
        return 16'h4000 + off;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        clear_all();
        tick();
        tick();
        total++; if (bus.core_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.core_ready); end
        total++; if (bus.mem_wren !== 1'b0 || bus.mem_rden !== 1'b0) begin bad++; $display("FAIL reset_strobes got wr=%b rd=%b exp 0 0", bus.mem_wren, bus.mem_rden); end
        total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_id); end
        total++; if (bus.core_read_val !== '0) begin bad++; $display("FAIL reset_read_val got=%h exp=0", bus.core_read_val); end
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        set_req(1, 1'b0, 1'b1, 16'h4010, 16'h0000);
        total++; if (bus.mem_rden !== 1'b0) begin bad++; $display("FAIL rd_c0_strobe got=%b exp=0", bus.mem_rden); end
        tick();
        total++; if (bus.mem_rden !== 1'b1 || bus.mem_wren !== 1'b0) begin bad++; $display("FAIL rd_c1_strobe got rd=%b wr=%b exp 1 0", bus.mem_rden, bus.mem_wren); end
        total++; if (bus.mem_addr !== 16'h4010) begin bad++; $display("FAIL rd_c1_addr got=%h exp=4010", bus.mem_addr); end
        total++; if (bus.core_ready !== 4'b0000) begin bad++; $display("FAIL rd_c1_ready got=%b exp=0000", bus.core_ready); end
        tick();
        total++; if (bus.core_ready !== 4'b0010) begin bad++; $display("FAIL rd_c2_ready got=%b exp=0010", bus.core_ready); end
        total++; if (bus.mem_rden !== 1'b0) begin bad++; $display("FAIL rd_c2_strobe got=%b exp=0", bus.mem_rden); end
        clear_all();
        tick();
        total++; if (bus.core_ready !== 4'b0000) begin bad++; $display("FAIL rd_c3_ready got=%b exp=0000", bus.core_ready); end
        total++; if (bus.core_read_val[31:16] !== 16'hBEEF) begin bad++; $display("FAIL rd_c3_data got=%h exp=beef", bus.core_read_val[31:16]); end
        tick();
        total++; if (bus.core_read_val[31:16] !== 16'hBEEF) begin bad++; $display("FAIL rd_c4_hold got=%h exp=beef", bus.core_read_val[31:16]); end
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 1'b0, 16'h8000, 16'h1234);
        tick();
        total++; if (bus.mem_wren !== 1'b1 || bus.mem_rden !== 1'b0) begin bad++; $display("FAIL wr_c1_strobe got wr=%b rd=%b exp 1 0", bus.mem_wren, bus.mem_rden); end
        total++; if (bus.mem_addr !== 16'h8000 || bus.mem_write_val !== 16'h1234) begin bad++; $display("FAIL wr_c1_bus got a=%h d=%h exp 8000 1234", bus.mem_addr, bus.mem_write_val); end
        tick();
        total++; if (bus.mem_wren !== 1'b0) begin bad++; $display("FAIL wr_c2_strobe got=%b exp=0", bus.mem_wren); end
        total++; if (bus.core_ready !== 4'b0001) begin bad++; $display("FAIL wr_c2_ready got=%b exp=0001", bus.core_ready); end
        clear_all();
        tick();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_rdy;
        int           k;
        reset = 1'b0;
        clear_all();
        tick();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, caddr(i), 16'h0000);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 16; c++) begin
            exp_rdy = '0;
            if (c >= 2 && (c - 2) % 3 == 0) exp_rdy[((c - 2) / 3) % N] = 1'b1;
            total++; if (bus.core_ready !== exp_rdy) begin bad++; $display("FAIL cont_ready c=%0d got=%b exp=%b", c, bus.core_ready, exp_rdy); end
            if (c >= 3 && (c - 3) % 3 == 0) begin
                k = ((c - 3) / 3) % N;
                total++; if (bus.core_read_val[16*k +: 16] !== lookup(caddr(k))) begin bad++; $display("FAIL cont_data core=%0d got=%h exp=%h", k, bus.core_read_val[16*k +: 16], lookup(caddr(k))); end
            end
            tick();
        end
        clear_all();
        repeat (3) tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_rdy;
        set_req(2, 1'b0, 1'b1, 16'h8200, 16'h0000);
        for (int c = 0; c < 12; c++) begin
            exp_rdy = '0;
            if (c == 2 || c == 5 || c == 11) exp_rdy[2] = 1'b1;
            if (c == 8) exp_rdy[3] = 1'b1;
            total++; if (bus.core_ready !== exp_rdy) begin bad++; $display("FAIL fair_ready c=%0d got=%b exp=%b", c, bus.core_ready, exp_rdy); end
            if (c == 7) begin
                total++; if (bus.grant_id !== 2'd3 || bus.mem_addr !== 16'h8300) begin bad++; $display("FAIL fair_grant got g=%0d a=%h exp 3 8300", bus.grant_id, bus.mem_addr); end
            end
            if (c == 5)  set_req(3, 1'b0, 1'b1, 16'h8300, 16'h0000);
            if (c == 8)  set_req(3, 1'b0, 1'b0, 16'h0000, 16'h0000);
            if (c == 11) clear_all();
            tick();
        end
    endtask

    task automatic test_both_strobes();
        total++; if (bus.core_read_val[15:0] !== lookup(caddr(0))) begin bad++; $display("FAIL both_pre got=%h exp=%h", bus.core_read_val[15:0], lookup(caddr(0))); end
        set_req(0, 1'b1, 1'b1, 16'hC000, 16'h5555);
        tick();
        total++; if (bus.mem_wren !== 1'b1 || bus.mem_rden !== 1'b0) begin bad++; $display("FAIL both_strobe got wr=%b rd=%b exp 1 0", bus.mem_wren, bus.mem_rden); end
        total++; if (bus.mem_addr !== 16'hC000 || bus.mem_write_val !== 16'h5555) begin bad++; $display("FAIL both_bus got a=%h d=%h exp c000 5555", bus.mem_addr, bus.mem_write_val); end
        tick();
        total++; if (bus.core_ready !== 4'b0001) begin bad++; $display("FAIL both_ready got=%b exp=0001", bus.core_ready); end
        clear_all();
        tick();
        total++; if (bus.core_read_val[15:0] !== lookup(caddr(0))) begin bad++; $display("FAIL both_keep got=%h exp=%h", bus.core_read_val[15:0], lookup(caddr(0))); end
    endtask

    task automatic test_async_reset();
        set_req(1, 1'b0, 1'b1, 16'h4321, 16'h0000);
        tick();
        total++; if (bus.mem_rden !== 1'b1) begin bad++; $display("FAIL ares_issue got=%b exp=1", bus.mem_rden); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.mem_rden !== 1'b0 || bus.mem_wren !== 1'b0) begin bad++; $display("FAIL ares_strobes got rd=%b wr=%b exp 0 0", bus.mem_rden, bus.mem_wren); end
        total++; if (bus.core_ready !== 4'b0000) begin bad++; $display("FAIL ares_ready got=%b exp=0000", bus.core_ready); end
        total++; if (bus.core_read_val !== '0) begin bad++; $display("FAIL ares_data got=%h exp=0", bus.core_read_val); end
        clear_all();
        set_req(0, 1'b0, 1'b1, 16'h4400, 16'h0000);
        set_req(2, 1'b0, 1'b1, 16'h4600, 16'h0000);
        tick();
        reset = 1'b1;
        tick();
        total++; if (bus.mem_rden !== 1'b1 || bus.mem_addr !== 16'h4400 || bus.grant_id !== 2'd0) begin bad++; $display("FAIL ares_first got rd=%b a=%h g=%0d exp 1 4400 0", bus.mem_rden, bus.mem_addr, bus.grant_id); end
        tick();
        total++; if (bus.core_ready !== 4'b0001) begin bad++; $display("FAIL ares_ready0 got=%b exp=0001", bus.core_ready); end
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        total++; if (bus.core_read_val[15:0] !== lookup(16'h4400)) begin bad++; $display("FAIL ares_data0 got=%h exp=%h", bus.core_read_val[15:0], lookup(16'h4400)); end
        tick();
        total++; if (bus.mem_addr !== 16'h4600 || bus.mem_rden !== 1'b1) begin bad++; $display("FAIL ares_second got a=%h rd=%b exp 4600 1", bus.mem_addr, bus.mem_rden); end
        tick();
        total++; if (bus.core_ready !== 4'b0100) begin bad++; $display("FAIL ares_ready2 got=%b exp=0100", bus.core_ready); end
        clear_all();
        tick();
        total++; if (bus.core_read_val[47:32] !== lookup(16'h4600)) begin bad++; $display("FAIL ares_data2 got=%h exp=%h", bus.core_read_val[47:32], lookup(16'h4600)); end
    endtask

    // Random traffic against a transaction schedule: each grant is a record
    // stamped with the cycle it was chosen; strobes, ready and data are
    // expected at fixed offsets from that stamp.
    task automatic test_random();
        logic        active [N];
        logic        a_wr   [N];
        logic        a_rd   [N];
        logic [15:0] a_addr [N];
        logic [15:0] a_data [N];
        logic [15:0] exp_rv [N];
        logic [N-1:0] exp_rdy;
        logic [1:0]  hi;
        logic [13:0] lo;
        int          last, free_t, s_t, s_w, kind, w;
        logic        s_vld, s_wr, s_rd, issue, resp;
        logic [15:0] s_addr, s_data;

        reset = 1'b0;
        clear_all();
        tick();
        reset  = 1'b1;
        last   = N - 1;
        free_t = 0;
        s_vld  = 1'b0;
        s_t = 0; s_w = 0; s_wr = 1'b0; s_rd = 1'b0; s_addr = '0; s_data = '0;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0; a_wr[i] = 1'b0; a_rd[i] = 1'b0;
            a_addr[i] = '0; a_data[i] = '0; exp_rv[i] = '0;
        end

        for (int t = 0; t < 700; t++) begin
            issue = s_vld && (t == s_t + 1);
            resp  = s_vld && (t == s_t + 2);
            exp_rdy = '0;
            if (resp) exp_rdy[s_w] = 1'b1;
            total++; if (bus.core_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, bus.core_ready, exp_rdy); end
            total++; if (bus.mem_wren !== (issue && s_wr) || bus.mem_rden !== (issue && s_rd)) begin bad++; $display("FAIL rnd_strobe t=%0d got wr=%b rd=%b exp %b %b", t, bus.mem_wren, bus.mem_rden, issue && s_wr, issue && s_rd); end
            if (issue) begin
                total++; if (bus.mem_addr !== s_addr || bus.grant_id !== 2'(s_w)) begin bad++; $display("FAIL rnd_issue t=%0d got a=%h g=%0d exp %h %0d", t, bus.mem_addr, bus.grant_id, s_addr, s_w); end
                if (s_wr) begin
                    total++; if (bus.mem_write_val !== s_data) begin bad++; $display("FAIL rnd_wdata t=%0d got=%h exp=%h", t, bus.mem_write_val, s_data); end
                end
            end
            for (int i = 0; i < N; i++) begin
                total++; if (bus.core_read_val[16*i +: 16] !== exp_rv[i]) begin bad++; $display("FAIL rnd_rdata t=%0d core=%0d got=%h exp=%h", t, i, bus.core_read_val[16*i +: 16], exp_rv[i]); end
            end

            // completion of the scheduled transaction
            if (resp) begin
                if (s_rd) exp_rv[s_w] = lookup(s_addr);
                active[s_w] = 1'b0;
                s_vld = 1'b0;
            end

            // idle cores may start a new request
            for (int i = 0; i < N; i++) begin
                if (!active[i] && $urandom_range(0, 2) == 0) begin
                    kind      = int'($urandom_range(0, 2));
                    hi        = 2'($urandom_range(1, 3));
                    lo        = 14'($urandom);
                    active[i] = 1'b1;
                    a_wr[i]   = (kind != 0);
                    a_rd[i]   = (kind != 1);
                    a_addr[i] = {hi, lo};
                    a_data[i] = 16'($urandom);
                end
                set_req(i, active[i] & a_wr[i], active[i] & a_rd[i], a_addr[i], a_data[i]);
            end

            // arbiter free: the nearest requester after the last winner goes next
            if (t >= free_t) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && active[(last + k) % N]) w = (last + k) % N;
                end
                if (w >= 0) begin
                    s_vld  = 1'b1;
                    s_t    = t;
                    s_w    = w;
                    s_wr   = a_wr[w];
                    s_rd   = a_rd[w] & ~a_wr[w];
                    s_addr = a_addr[w];
                    s_data = a_data[w];
                    last   = w;
                    free_t = t + 3;
                end
            end
            tick();
        end
        clear_all();
        repeat (4) tick();
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_fairness();
        test_both_strobes();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/remote_bus_arbiter.md
Name: remote_bus_arbiter

Overview:
- Sits directly downstream of N core instances and consumes each core's remote_* request interface (addresses with bits 15:14 != 2'b00).
- Arbitrates round-robin among cores and issues one access at a time to a shared synchronous memory/device port with fixed 1-cycle read latency.
- Returns per-core ready and read data with the timing the core pipeline expects: the core stalls while ready is low and samples read data the cycle after ready.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- CORE_ID_WIDTH, $clog2(NUM_CORES), width of grant index.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- core_addr  input  NUM_CORES*16  per-core remote_addr; slice i = [16*i+15:16*i].
- core_wren  input  NUM_CORES  per-core remote_wren.
- core_rden  input  NUM_CORES  per-core remote_rden.
- core_write_val  input  NUM_CORES*16  per-core remote_write_val.
- core_ready  output  NUM_CORES  per-core remote_ready.
- core_read_val  output  NUM_CORES*16  per-core remote_read_val.
- mem_addr  output  16  shared port address.
- mem_wren  output  1  shared port write strobe.
- mem_rden  output  1  shared port read strobe.
- mem_write_val  output  16  shared port write data.
- mem_read_val  input  16  shared port read data, valid 1 cycle after mem_rden.
- grant_id  output  CORE_ID_WIDTH  index of the core currently owning the port (debug).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; core_ready=0; all core_read_val registers=0.
  - mem_wren=0, mem_rden=0; grant_id=0; round-robin pointer last=NUM_CORES-1, so core 0 has first priority.
- A request from core i is core_wren[i] | core_rden[i]. The core holds its address and data stable while core_ready[i]=0.
- FSM states:
  - IDLE: if any request, pick the first requesting i searching last+1, last+2, ... (mod NUM_CORES); register grant_id=i; go to ISSUE. With no request, stay in IDLE.
  - ISSUE (1 cycle):
    - mem_addr, mem_write_val = slices of core grant_id.
    - mem_wren = core_wren[grant_id].
    - mem_rden = core_rden[grant_id] & ~core_wren[grant_id]; write wins if both are set.
    - Go to RESP.
  - RESP (1 cycle):
    - core_ready[grant_id]=1 (registered, driven from state); all other ready bits 0.
    - If the access was a read, load core_read_val[grant_id] <= mem_read_val at the end of this cycle.
    - last <= grant_id; go to IDLE.
- mem_wren and mem_rden are 0 outside ISSUE. mem_addr and mem_write_val are don't-care outside ISSUE but must be driven, not X.
- Latency, measured from the first cycle a request is seen in IDLE:
  - ready at cycle +2 (RESP).
  - read data on core_read_val at cycle +3 and held until that core's next read completes.
  - Throughput is one transaction per 3 cycles.
- core_ready is at most one-hot and high for exactly one cycle per transaction.
- Simultaneous requests: served in round-robin order. No core waits more than NUM_CORES transactions.
- Request dropped while granted (possible only via core reset): the transaction still completes. A write still occurs; a spurious ready is harmless.
- Requests arriving during ISSUE or RESP are seen at the next IDLE.
- Reset mid-transaction: FSM returns to IDLE immediately and no further mem strobes are issued. An in-flight write may or may not have completed, depending on whether ISSUE had occurred.
- No combinational path from core_* inputs to core_ready.

Test Plan:
- Single read: core 1 rden, addr 0x4010; mem returns 0xBEEF.
  - mem_rden=1 with mem_addr=0x4010 at cycle 1.
  - core_ready[1]=1 at cycle 2 only.
  - core_read_val[1]=0xBEEF from cycle 3 on.
- Single write: core 0 wren, addr 0x8000, data 0x1234 → mem_wren=1, mem_addr=0x8000, mem_write_val=0x1234 for exactly 1 cycle; core_ready[0] pulses 1 cycle later.
- Contention: all 4 cores request reads continuously from reset → grants in order 0,1,2,3,0; ready pulses every 3 cycles; each core_read_val matches its own address's data.
- Fairness: core 2 requests constantly and core 3 requests once at cycle 5 → core 3 is granted immediately after the in-flight core-2 transaction, with no second core-2 grant before it.
- Both strobes: core 0 asserts wren and rden together → mem_wren=1 and mem_rden=0; core_read_val[0] is unchanged.
- Async reset: assert reset=0 during ISSUE of a read → core_ready=0 and mem strobes=0 immediately. After release, a new request is served from core 0 priority with correct latency.
